multicycle_ctrl: RTL and testbench

//  Main control FSM for the multi-cycle MIPS core. Sequences the shared datapath (PC, unified memory, IR, regfile, ALU).

---
 rtl/mc_ctrl_pkg.sv | 50 +++++
 rtl/multicycle_ctrl_if.sv | 36 +++
 rtl/mc_wait_timer.sv | 37 +++
 rtl/multicycle_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 160 ++++++++++++++++
 5 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control FSM: state codes,
// supported opcodes, datapath mux selects and halt causes.
package mc_ctrl_pkg;

    typedef logic [3:0] state_t;

    localparam state_t ST_FETCH  = 4'd0;
    localparam state_t ST_DECODE = 4'd1;
    localparam state_t ST_MEMADR = 4'd2;
    localparam state_t ST_MEMRD  = 4'd3;
    localparam state_t ST_MEMWB  = 4'd4;
    localparam state_t ST_MEMWR  = 4'd5;
    localparam state_t ST_REX    = 4'd6;
    localparam state_t ST_RWB    = 4'd7;
    localparam state_t ST_IEX    = 4'd8;
    localparam state_t ST_IWB    = 4'd9;
    localparam state_t ST_BEQ    = 4'd10;
    localparam state_t ST_JMP    = 4'd11;
    localparam state_t ST_HALT   = 4'd12;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [1:0] ALUSRCB_B     = 2'd0;
    localparam logic [1:0] ALUSRCB_FOUR  = 2'd1;
    localparam logic [1:0] ALUSRCB_IMM   = 2'd2;
    localparam logic [1:0] ALUSRCB_IMMSH = 2'd3;

    localparam logic [1:0] ALUOP_ADD   = 2'd0;
    localparam logic [1:0] ALUOP_SUB   = 2'd1;
    localparam logic [1:0] ALUOP_FUNCT = 2'd2;

    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;

    localparam logic [1:0] CAUSE_NONE    = 2'd0;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'd2;

    // States that hold a memory request open until mem_ready arrives.
    function automatic logic is_wait_state(input state_t s);
        return (s == ST_FETCH) || (s == ST_MEMRD) || (s == ST_MEMWR);
    endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Control bus between the multi-cycle FSM (master) and the datapath (slave).
interface multicycle_ctrl_if;

    logic [5:0] opcode;
    logic       mem_ready;
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       halted;
    logic [1:0] halt_cause;

    modport master (
        input  opcode, mem_ready,
        output pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
               pc_source, halted, halt_cause
    );

    modport slave (
        output opcode, mem_ready,
        input  pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
               pc_source, halted, halt_cause
    );

endinterface

// File: rtl/mc_wait_timer.sv
// Memory wait counter: counts cycles spent waiting for mem_ready and flags
// when the count has reached MAX.
module mc_wait_timer #(
    parameter int MAX = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic inc_i,
    output logic timeout_o
);

    localparam int W = (MAX < 1) ? 1 : $clog2(MAX + 1);
    localparam logic [W-1:0] MAX_V = W'(MAX);

    logic [W-1:0] cnt_q, cnt_d;

    // Clear wins over increment; the count never runs past MAX.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (inc_i && (cnt_q != MAX_V))
            cnt_d = cnt_q + W'(1);
    end

    // Count register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign timeout_o = (cnt_q == MAX_V);

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multi-cycle MIPS core. Optional performance
// counters are built when MC_CTRL_PERF_EN is defined.
module multicycle_ctrl
    import mc_ctrl_pkg::*;
#(
    parameter int MEM_WAIT_MAX = 15
`ifdef MC_CTRL_PERF_EN
    , parameter int CNT_W = 32
`endif
) (
    input  logic                clk,
    input  logic                rst,
    multicycle_ctrl_if.master   bus
`ifdef MC_CTRL_PERF_EN
    , output logic [CNT_W-1:0]  cycle_cnt
    , output logic [CNT_W-1:0]  instr_cnt
`endif
);

    state_t     state_q, state_d;
    logic [1:0] cause_q, cause_d;
    logic       timeout;
    logic       wait_st;
    logic       tmo_hit;

    assign wait_st = is_wait_state(state_q);
    // A ready in the same cycle as the limit is still accepted.
    assign tmo_hit = wait_st && timeout && !bus.mem_ready;

    mc_wait_timer #(.MAX(MEM_WAIT_MAX)) u_timer (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (state_d != state_q),
        .inc_i     (wait_st && !bus.mem_ready),
        .timeout_o (timeout)
    );

    // Next-state and halt-cause selection.
    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        case (state_q)
            ST_FETCH: begin
                if (bus.mem_ready) state_d = ST_DECODE;
                else if (tmo_hit) begin state_d = ST_HALT; cause_d = CAUSE_TIMEOUT; end
            end
            ST_DECODE: begin
                case (bus.opcode)
                    OP_LW, OP_SW: state_d = ST_MEMADR;
                    OP_RTYPE:     state_d = ST_REX;
                    OP_ADDI:      state_d = ST_IEX;
                    OP_BEQ:       state_d = ST_BEQ;
                    OP_J:         state_d = ST_JMP;
                    default: begin state_d = ST_HALT; cause_d = CAUSE_ILLEGAL; end
                endcase
            end
            ST_MEMADR: state_d = (bus.opcode == OP_LW) ? ST_MEMRD : ST_MEMWR;
            ST_MEMRD: begin
                if (bus.mem_ready) state_d = ST_MEMWB;
                else if (tmo_hit) begin state_d = ST_HALT; cause_d = CAUSE_TIMEOUT; end
            end
            ST_MEMWB: state_d = ST_FETCH;
            ST_MEMWR: begin
                if (bus.mem_ready) state_d = ST_FETCH;
                else if (tmo_hit) begin state_d = ST_HALT; cause_d = CAUSE_TIMEOUT; end
            end
            ST_REX:  state_d = ST_RWB;
            ST_RWB:  state_d = ST_FETCH;
            ST_IEX:  state_d = ST_IWB;
            ST_IWB:  state_d = ST_FETCH;
            ST_BEQ:  state_d = ST_FETCH;
            ST_JMP:  state_d = ST_FETCH;
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_HALT;
        endcase
    end

    // State and halt-cause registers; reset aborts any instruction in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_FETCH;
            cause_q <= CAUSE_NONE;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
        end
    end

    // Strobe decode from the registered state, forced low during reset and
    // in a timeout cycle so no memory/register write escapes.
    always_comb begin
        bus.pc_write      = 1'b0;
        bus.pc_write_cond = 1'b0;
        bus.iord          = 1'b0;
        bus.mem_read      = 1'b0;
        bus.mem_write     = 1'b0;
        bus.ir_write      = 1'b0;
        bus.mem_to_reg    = 1'b0;
        bus.reg_dst       = 1'b0;
        bus.reg_write     = 1'b0;
        bus.alu_src_a     = 1'b0;
        bus.alu_src_b     = ALUSRCB_B;
        bus.alu_op        = ALUOP_ADD;
        bus.pc_source     = PCSRC_ALU;
        if (!rst && !tmo_hit) begin
            case (state_q)
                ST_FETCH: begin
                    bus.mem_read  = 1'b1;
                    bus.alu_src_b = ALUSRCB_FOUR;
                    bus.ir_write  = bus.mem_ready;
                    bus.pc_write  = bus.mem_ready;
                end
                ST_DECODE: bus.alu_src_b = ALUSRCB_IMMSH;
                ST_MEMADR: begin
                    bus.alu_src_a = 1'b1;
                    bus.alu_src_b = ALUSRCB_IMM;
                end
                ST_MEMRD: begin
                    bus.mem_read = 1'b1;
                    bus.iord     = 1'b1;
                end
                ST_MEMWB: begin
                    bus.reg_write  = 1'b1;
                    bus.mem_to_reg = 1'b1;
                end
                ST_MEMWR: begin
                    bus.mem_write = 1'b1;
                    bus.iord      = 1'b1;
                end
                ST_REX: begin
                    bus.alu_src_a = 1'b1;
                    bus.alu_op    = ALUOP_FUNCT;
                end
                ST_RWB: begin
                    bus.reg_write = 1'b1;
                    bus.reg_dst   = 1'b1;
                end
                ST_IEX: begin
                    bus.alu_src_a = 1'b1;
                    bus.alu_src_b = ALUSRCB_IMM;
                end
                ST_IWB: bus.reg_write = 1'b1;
                ST_BEQ: begin
                    bus.alu_src_a     = 1'b1;
                    bus.alu_op        = ALUOP_SUB;
                    bus.pc_write_cond = 1'b1;
                    bus.pc_source     = PCSRC_ALUOUT;
                end
                ST_JMP: begin
                    bus.pc_write  = 1'b1;
                    bus.pc_source = PCSRC_JUMP;
                end
                default: ;
            endcase
        end
    end

    assign bus.halted     = (state_q == ST_HALT);
    assign bus.halt_cause = cause_q;

`ifdef MC_CTRL_PERF_EN
    logic [CNT_W-1:0] cycle_q, instr_q;

    // Performance counters; both freeze once the FSM halts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_q <= '0;
            instr_q <= '0;
        end else begin
            if (state_q != ST_HALT)
                cycle_q <= cycle_q + CNT_W'(1);
            if ((state_d == ST_FETCH) && (state_q != ST_FETCH))
                instr_q <= instr_q + CNT_W'(1);
        end
    end

    assign cycle_cnt = cycle_q;
    assign instr_cnt = instr_q;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed self-checking bench for multicycle_ctrl.
module tb_multicycle_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    multicycle_ctrl_if bus ();

`ifdef MC_CTRL_PERF_EN
    logic [31:0] cycle_cnt, instr_cnt;
    multicycle_ctrl #(.MEM_WAIT_MAX(15), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .bus(bus), .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt));
`else
    multicycle_ctrl #(.MEM_WAIT_MAX(15)) dut (.clk(clk), .rst(rst), .bus(bus));
`endif

    always #5 clk = ~clk;

    logic [15:0] E_ZERO, E_FETCH_W, E_FETCH_R, E_DECODE, E_MEMADR, E_MEMRD, E_MEMWB;
    logic [15:0] E_MEMWR, E_REX, E_RWB, E_IEX, E_IWB, E_BEQ, E_JMP;

    // Field order: pw pwc iord mr mw irw m2r rdst rw asa asb aop psrc
    function automatic logic [15:0] mk(input logic pw, pwc, iord, mr, mw, irw, m2r, rdst, rw, asa,
                                       input logic [1:0] asb, aop, psrc);
        return {pw, pwc, iord, mr, mw, irw, m2r, rdst, rw, asa, asb, aop, psrc};
    endfunction

    function automatic logic [15:0] strobes();
        return {bus.pc_write, bus.pc_write_cond, bus.iord, bus.mem_read, bus.mem_write,
                bus.ir_write, bus.mem_to_reg, bus.reg_dst, bus.reg_write, bus.alu_src_a,
                bus.alu_src_b, bus.alu_op, bus.pc_source};
    endfunction

    task automatic check(input string tag, input logic [15:0] es, input logic eh, input logic [1:0] ec);
        logic [18:0] obs, exp;
        obs = {strobes(), bus.halted, bus.halt_cause};
        exp = {es, eh, ec};
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One cycle: drive inputs on the falling edge, check shortly after.
    task automatic cyc(input logic [5:0] op, input logic rdy, input logic [15:0] es,
                       input logic eh, input logic [1:0] ec, input string tag);
        @(negedge clk);
        bus.opcode    = op;
        bus.mem_ready = rdy;
        #1;
        check(tag, es, eh, ec);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst           = 1'b1;
        bus.mem_ready = 1'b0;
        #1;
        check(tag, E_ZERO, 1'b0, 2'd0);
`ifdef MC_CTRL_PERF_EN
        total++;
        assert ({cycle_cnt, instr_cnt} === 64'd0) else begin
            bad++;
            $error("FAIL %s_perf: observed=%h expected=0", tag, {cycle_cnt, instr_cnt});
        end
`endif
        rst = 1'b0;
    endtask

    initial begin
        E_ZERO    = mk(0,0,0,0,0,0,0,0,0,0, 2'd0, 2'd0, 2'd0);
        E_FETCH_W = mk(0,0,0,1,0,0,0,0,0,0, 2'd1, 2'd0, 2'd0);
        E_FETCH_R = mk(1,0,0,1,0,1,0,0,0,0, 2'd1, 2'd0, 2'd0);
        E_DECODE  = mk(0,0,0,0,0,0,0,0,0,0, 2'd3, 2'd0, 2'd0);
        E_MEMADR  = mk(0,0,0,0,0,0,0,0,0,1, 2'd2, 2'd0, 2'd0);
        E_MEMRD   = mk(0,0,1,1,0,0,0,0,0,0, 2'd0, 2'd0, 2'd0);
        E_MEMWB   = mk(0,0,0,0,0,0,1,0,1,0, 2'd0, 2'd0, 2'd0);
        E_MEMWR   = mk(0,0,1,0,1,0,0,0,0,0, 2'd0, 2'd0, 2'd0);
        E_REX     = mk(0,0,0,0,0,0,0,0,0,1, 2'd0, 2'd2, 2'd0);
        E_RWB     = mk(0,0,0,0,0,0,0,1,1,0, 2'd0, 2'd0, 2'd0);
        E_IEX     = mk(0,0,0,0,0,0,0,0,0,1, 2'd2, 2'd0, 2'd0);
        E_IWB     = mk(0,0,0,0,0,0,0,0,1,0, 2'd0, 2'd0, 2'd0);
        E_BEQ     = mk(0,1,0,0,0,0,0,0,0,1, 2'd0, 2'd1, 2'd1);
        E_JMP     = mk(1,0,0,0,0,0,0,0,0,0, 2'd0, 2'd0, 2'd2);
        bus.opcode    = 6'h00;
        bus.mem_ready = 1'b0;

        do_reset("reset");

        // add: FETCH, DECODE, REX, RWB
        cyc(6'h00, 1'b1, E_FETCH_R, 0, 0, "add_fetch");
        cyc(6'h00, 1'b0, E_DECODE,  0, 0, "add_decode");
        cyc(6'h00, 1'b0, E_REX,     0, 0, "add_rex");
        cyc(6'h00, 1'b0, E_RWB,     0, 0, "add_rwb");

        // lw with three wait cycles in MEMRD
        cyc(6'h23, 1'b1, E_FETCH_R, 0, 0, "lw_fetch");
        cyc(6'h23, 1'b0, E_DECODE,  0, 0, "lw_decode");
        cyc(6'h23, 1'b0, E_MEMADR,  0, 0, "lw_memadr");
        for (int i = 0; i < 3; i++)
            cyc(6'h23, 1'b0, E_MEMRD, 0, 0, "lw_memrd_wait");
        cyc(6'h23, 1'b1, E_MEMRD,   0, 0, "lw_memrd_done");
        cyc(6'h23, 1'b0, E_MEMWB,   0, 0, "lw_memwb");

        // addi, ready asserted outside wait states is ignored
        cyc(6'h08, 1'b1, E_FETCH_R, 0, 0, "addi_fetch");
        cyc(6'h08, 1'b1, E_DECODE,  0, 0, "addi_decode");
        cyc(6'h08, 1'b1, E_IEX,     0, 0, "addi_iex");
        cyc(6'h08, 1'b0, E_IWB,     0, 0, "addi_iwb");

        // beq then j
        cyc(6'h04, 1'b1, E_FETCH_R, 0, 0, "beq_fetch");
        cyc(6'h04, 1'b0, E_DECODE,  0, 0, "beq_decode");
        cyc(6'h04, 1'b0, E_BEQ,     0, 0, "beq_exec");
        cyc(6'h02, 1'b1, E_FETCH_R, 0, 0, "j_fetch");
        cyc(6'h02, 1'b0, E_DECODE,  0, 0, "j_decode");
        cyc(6'h02, 1'b0, E_JMP,     0, 0, "j_exec");

        // sw with fetch waits, reset pulsed while MEMWR waits
        cyc(6'h2B, 1'b0, E_FETCH_W, 0, 0, "sw_fetch_wait");
        cyc(6'h2B, 1'b0, E_FETCH_W, 0, 0, "sw_fetch_wait");
        cyc(6'h2B, 1'b1, E_FETCH_R, 0, 0, "sw_fetch");
        cyc(6'h2B, 1'b0, E_DECODE,  0, 0, "sw_decode");
        cyc(6'h2B, 1'b0, E_MEMADR,  0, 0, "sw_memadr");
        cyc(6'h2B, 1'b0, E_MEMWR,   0, 0, "sw_memwr");
        #2;
        rst = 1'b1;
        #1;
        check("rst_async", E_ZERO, 1'b0, 2'd0);
        do_reset("rst_held");

        // illegal opcode halts, strobes stay low for 20 cycles
        cyc(6'h3F, 1'b1, E_FETCH_R, 0, 0, "ill_fetch");
        cyc(6'h3F, 1'b0, E_DECODE,  0, 0, "ill_decode");
        for (int i = 0; i < 20; i++)
            cyc(6'h3F, logic'(i % 2), E_ZERO, 1, 2'd1, "ill_halt");

        // memory timeout in FETCH: count 0 consumed during reset release
        do_reset("to_reset");
        for (int i = 1; i < 15; i++)
            cyc(6'h00, 1'b0, E_FETCH_W, 0, 0, "to_fetch_wait");
        cyc(6'h00, 1'b0, E_ZERO, 0, 0, "to_limit_cycle");
        for (int i = 0; i < 3; i++)
            cyc(6'h00, 1'b1, E_ZERO, 1, 2'd2, "to_halt");

        // ready in the limit cycle is accepted
        do_reset("lim_reset");
        for (int i = 1; i < 15; i++)
            cyc(6'h00, 1'b0, E_FETCH_W, 0, 0, "lim_fetch_wait");
        cyc(6'h00, 1'b1, E_FETCH_R, 0, 0, "lim_accept");
        cyc(6'h00, 1'b0, E_DECODE,  0, 0, "lim_decode");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
